// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared types and constants for the AES-128 round controllers
package aes_ctrl_pkg;

  localparam int NR_AES128 = 10;
  localparam int AES_BW    = 128;
  localparam int AES_KW    = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SUB   = 3'd3,
    SHIFT = 3'd4,
    MIX   = 3'd5,
    GAP   = 3'd6,
    DONE  = 3'd7
  } aesState_e;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_SHIFT = 2'd2,
    OP_MIX   = 2'd3
  } aesOp_e;

  typedef enum logic {
    DIR_ENC = 1'b0,
    DIR_DEC = 1'b1
  } aesDir_e;

  function automatic aesState_e opToState(aesOp_e op);
    aesState_e st;
    case (op)
      OP_ADD:   st = ADD;
      OP_SUB:   st = SUB;
      OP_SHIFT: st = SHIFT;
      OP_MIX:   st = MIX;
      default:  st = ADD;
    endcase
    return st;
  endfunction

  // Non-op states map to OP_ADD; callers only use this inside op states.
  function automatic aesOp_e stateToOp(aesState_e st);
    aesOp_e op;
    case (st)
      SUB:     op = OP_SUB;
      SHIFT:   op = OP_SHIFT;
      MIX:     op = OP_MIX;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - next-op / next-round decision shared by the AES encryptor and decryptor
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int KW = AES_KW
) (
  input  aesDir_e       dir,
  input  aesOp_e        lastOp,
  input  logic [KW-1:0] round,
  input  logic [KW-1:0] numRounds,
  output aesOp_e        nextOp,
  output logic [KW-1:0] nextRound,
  output logic          finish
);

  always_comb begin
    nextOp    = OP_ADD;
    nextRound = round;
    finish    = 1'b0;
    if (dir == DIR_ENC) begin
      // Forward cipher: rounds count up, the last round skips MixColumns.
      case (lastOp)
        OP_ADD: begin
          if (round < numRounds) begin
            nextOp    = OP_SUB;
            nextRound = round + 1'b1;
          end else begin
            finish = 1'b1;
          end
        end
        OP_SUB:   nextOp = OP_SHIFT;
        OP_SHIFT: nextOp = (round < numRounds) ? OP_MIX : OP_ADD;
        OP_MIX:   nextOp = OP_ADD;
        default:  nextOp = OP_ADD;
      endcase
    end else begin
      // Inverse cipher: rounds count down from numRounds; InvMixColumns
      // follows every AddRoundKey except the first and the last.
      case (lastOp)
        OP_ADD: begin
          if (round == '0) begin
            finish = 1'b1;
          end else if (round == numRounds) begin
            nextOp    = OP_SHIFT;
            nextRound = round - 1'b1;
          end else begin
            nextOp = OP_MIX;
          end
        end
        OP_MIX: begin
          nextOp    = OP_SHIFT;
          nextRound = round - 1'b1;
        end
        OP_SHIFT: nextOp = OP_SUB;
        OP_SUB:   nextOp = OP_ADD;
        default:  nextOp = OP_ADD;
      endcase
    end
  end

endmodule

// File: rtl/aes_encrypt_fsm.sv
// rtl/aes_encrypt_fsm.sv - AES-128 encryption controller driving shared round units
module aes_encrypt_fsm
  import aes_ctrl_pkg::*;
#(
  parameter int NR = NR_AES128,
  parameter int BW = AES_BW,
  parameter int KW = AES_KW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          En,
  input  logic [BW-1:0] PT,
  output logic [KW-1:0] SelKey,
  output logic          Ry,
  output logic [BW-1:0] CT,
  output logic          AddEn,
  output logic          SubEn,
  output logic          ShiftEn,
  output logic          MixEn,
  input  logic          AddRy,
  input  logic          SubRy,
  input  logic          ShiftRy,
  input  logic          MixRy,
  output logic [BW-1:0] Text,
  input  logic [BW-1:0] ModifiedText
);

  aesState_e     state;
  aesState_e     nextState;
  aesOp_e        lastOp;
  aesOp_e        seqNextOp;
  logic [BW-1:0] stateText;
  logic [BW-1:0] cipherText;
  logic [KW-1:0] round;
  logic [KW-1:0] seqNextRound;
  logic          seqFinish;
  logic          unitDone;

  aes_round_sequencer #(
    .KW(KW)
  ) uSeq (
    .dir       (DIR_ENC),
    .lastOp    (lastOp),
    .round     (round),
    .numRounds (KW'(NR)),
    .nextOp    (seqNextOp),
    .nextRound (seqNextRound),
    .finish    (seqFinish)
  );

  // Only the ready of the unit we enabled counts; strays are ignored.
  always_comb begin
    unitDone = 1'b0;
    case (state)
      ADD:     unitDone = AddRy;
      SUB:     unitDone = SubRy;
      SHIFT:   unitDone = ShiftRy;
      MIX:     unitDone = MixRy;
      default: unitDone = 1'b0;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (En) nextState = LOAD;
      LOAD:  nextState = ADD;
      ADD, SUB, SHIFT, MIX: begin
        if (unitDone) nextState = GAP;
      end
      GAP:   nextState = seqFinish ? DONE : opToState(seqNextOp);
      DONE:  if (!En) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stateText  <= '0;
      cipherText <= '0;
      round      <= '0;
      lastOp     <= OP_ADD;
    end else begin
      case (state)
        IDLE: begin
          if (En) begin
            stateText <= PT;
            round     <= '0;
          end
        end
        ADD, SUB, SHIFT, MIX: begin
          if (unitDone) begin
            stateText <= ModifiedText;
            lastOp    <= stateToOp(state);
          end
        end
        GAP: begin
          if (seqFinish) begin
            cipherText <= stateText;
          end else begin
            round <= seqNextRound;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign AddEn   = (state == ADD);
  assign SubEn   = (state == SUB);
  assign ShiftEn = (state == SHIFT);
  assign MixEn   = (state == MIX);
  assign Ry      = (state == DONE);
  assign SelKey  = round;
  assign Text    = stateText;
  assign CT      = cipherText;

endmodule
